// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int COL_W    = 2;
    localparam int ROW_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Outcome of one full four-column scan.
    typedef enum logic [1:0] {
        SCAN_NONE  = 2'd0,
        SCAN_ONE   = 2'd1,
        SCAN_MULTI = 2'd2
    } scan_cls_e;

    // Physical keypad legend: row/column position to hex code.
    function automatic logic [3:0] key_code(input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Column-step timebase: free-running divider with a one-clock tick at terminal count.
module scan_tick #(
    parameter int CLK_XTAL = 50000000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV   = (CLK_XTAL / SCAN_HZ > 0) ? CLK_XTAL / SCAN_HZ : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q;

    // Divider counts 0..DIV-1 and wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (div_q == DIV_TC) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_TC);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronizer, per-scan classification,
// and a press/release debounce FSM producing a hex code plus a valid pulse.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | no key accepted; waiting for a scan with exactly one key
//   DEBOUNCE | candidate key seen on cnt consecutive scans
//   PRESSED  | key accepted, key_down high, waiting for an empty scan
//   RELEASE  | empty scans counted; key_down drops once confirmed
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_XTAL       = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] filas,
    output logic [NUM_COLS-1:0] columnas,
    output logic [3:0]          key_value,
    output logic                key_valid,
    output logic                key_down
);

    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                tick;
    logic [NUM_ROWS-1:0] sync1_q, sync2_q;
    logic [COL_W-1:0]    col_q;
    logic [1:0]          acc_hits_q;
    logic [3:0]          acc_code_q;

    logic [1:0]          cur_hits;
    logic [ROW_W-1:0]    cur_row;
    logic [3:0]          cur_code;
    logic [1:0]          base_hits;
    logic [2:0]          hit_sum;
    logic [1:0]          tot_hits;
    logic [3:0]          tot_code;
    logic                scan_end;
    scan_cls_e           scan_cls;

    kp_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [3:0]          cand_q, cand_d;
    logic [3:0]          key_value_q, key_value_d;
    logic                key_valid_q, key_valid_d;

    scan_tick #(
        .CLK_XTAL (CLK_XTAL),
        .SCAN_HZ  (SCAN_HZ)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= filas;
            sync2_q <= sync1_q;
        end
    end

    // Low rows in the current column: count saturates at 2, code from the lowest row.
    always_comb begin
        cur_hits = 2'd0;
        cur_row  = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!sync2_q[r]) begin
                cur_row = ROW_W'(r);
                if (cur_hits != 2'd2) begin
                    cur_hits = cur_hits + 2'd1;
                end
            end
        end
        cur_code = key_code(cur_row, col_q);
    end

    // Fold this column into the running scan result; column 0 starts a fresh scan.
    always_comb begin
        base_hits = (col_q == '0) ? 2'd0 : acc_hits_q;
        hit_sum   = {1'b0, base_hits} + {1'b0, cur_hits};
        tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_code  = (base_hits != 2'd0) ? acc_code_q : cur_code;
        scan_end  = tick && (col_q == COL_W'(NUM_COLS - 1));
        case (tot_hits)
            2'd0:    scan_cls = SCAN_NONE;
            2'd1:    scan_cls = SCAN_ONE;
            default: scan_cls = SCAN_MULTI;
        endcase
    end

    // Column index and scan accumulator advance on every tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            acc_hits_q <= 2'd0;
            acc_code_q <= 4'h0;
        end else if (tick) begin
            col_q      <= col_q + 1'b1;
            acc_hits_q <= tot_hits;
            acc_code_q <= tot_code;
        end
    end

    // FSM state register together with the debounce counter and key registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_value_q <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state logic; decisions are taken only when a scan completes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_value_d = key_value_q;
        key_valid_d = 1'b0;
        cnt_inc     = cnt_q + 1'b1;
        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_cls == SCAN_ONE) begin
                        cand_d = tot_code;
                        cnt_d  = CNT_ONE;
                        if (DEBOUNCE_SCANS <= 1) begin
                            key_value_d = tot_code;
                            key_valid_d = 1'b1;
                            state_d     = ST_PRESSED;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_cls == SCAN_ONE && tot_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            key_value_d = cand_q;
                            key_valid_d = 1'b1;
                            state_d     = ST_PRESSED;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (scan_cls == SCAN_NONE) begin
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE_SCANS <= 1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (scan_cls == SCAN_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: one column driven low, key held while pressed or releasing.
    always_comb begin
        columnas  = ~(NUM_COLS'(1) << col_q);
        key_value = key_value_q;
        key_valid = key_valid_q;
        key_down  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed 7-segment display driver: the display drives anodes outward, this block drives keypad columns and reads rows back.
- Scans a 4x4 hex matrix keypad, debounces, and decodes one pressed key into a 4-bit hex value plus a single-cycle valid pulse.
- Sits beside the display path; its value output is intended to feed the same number-to-show datapath the banner uses.

Parameters:
- CLK_XTAL, 50000000, input clock frequency in Hz.
- SCAN_HZ, 1000, column-step rate in Hz. Tick period = CLK_XTAL/SCAN_HZ clocks; integer division.
- DEBOUNCE_SCANS, 4, number of consecutive identical full scans needed to accept a press or a release. Minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- filas  in  4  keypad rows, pulled up, low = key in driven column pressed; asynchronous to clk.
- columnas  out  4  column drive, active-low, exactly one bit low.
- key_value  out  4  hex code of last accepted key; holds until next accept.
- key_valid  out  1  one-clock pulse when key_value is updated.
- key_down  out  1  level, high from accept until release is confirmed.

Behaviour:
- Reset values: columnas=4'b1110, key_value=0, key_valid=0, key_down=0, FSM=IDLE, divider=0, column index=0, debounce count=0, synchronizer flops=4'hF.
- filas passes through a 2-flop synchronizer. Rows are sampled only on a scan tick, so settle time is one full tick period.
- Tick: the divider counts 0..CLK_XTAL/SCAN_HZ-1 and asserts tick for one clock at terminal count.
- On each tick:
  - Sample the synced rows for the current column, then advance the column index 0→1→2→3→0.
  - columnas = ~(1<<col).
- A full scan ends on the tick that samples column 3. The scan result is classified as:
  - NONE: no low rows anywhere in the scan.
  - ONE(code): exactly one low row/column pair in the scan.
  - MULTI: two or more.
- Key map (row,col → code):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- FSM transitions are evaluated only at scan end:
  - IDLE:
    - ONE(c): latch cand=c, cnt=1, go DEBOUNCE. If DEBOUNCE_SCANS=1, accept immediately.
    - Otherwise stay.
  - DEBOUNCE:
    - ONE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, set key_value=cand, pulse key_valid, set key_down=1, go PRESSED.
    - ONE(other), NONE, or MULTI: go IDLE, cnt=0.
  - PRESSED:
    - NONE: cnt=1, go RELEASE.
    - ONE or MULTI: stay. No auto-repeat and no second valid pulse.
  - RELEASE:
    - NONE: cnt++. At DEBOUNCE_SCANS, clear key_down and go IDLE.
    - ONE or MULTI: go PRESSED with no new valid.
- Latency: with a key stable from scan start, key_valid fires on the clock following the final tick of scan DEBOUNCE_SCANS.
- A press straddling a scan start is counted from the first complete scan containing it.
- Reset asserted at any time clears all state immediately. A pending debounce is lost and no pulse occurs after reset release.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encoding (IDLE, DEBOUNCE, PRESSED, RELEASE).
  - NUM_COLS=4 and NUM_ROWS=4.
  - The key map as a constant function mapping {row,col} to 4-bit code.
- One sub-module, scan_tick: divider plus tick output, parameterised by CLK_XTAL and SCAN_HZ, same reset polarity.
- The existing clk_div is not reused because its reset polarity differs.

Test Plan (CLK_XTAL=16, SCAN_HZ=4 → tick every 4 clks, scan = 16 clks; DEBOUNCE_SCANS=3):
- Reset: hold rst=0 → columnas=1110, key_value=0, key_valid=0, key_down=0. After release, columnas steps 1110→1101→1011→0111→1110 every 4 clks.
- Clean press '5' (row1 low while col1 driven), held 6 scans → exactly one key_valid pulse at end of scan 3, key_value=5, key_down=1, no further pulses.
- Bounce on 'A' (row0/col3), present and absent on alternate scans for 8 scans → no key_valid, key_down stays 0.
- Keys '1' and '2' held together for 4 scans → no valid. Then '2' released, '1' held → valid with key_value=1 exactly 3 scans later.
- Release of 'D': after accept, release → key_down falls after 3 empty scans. A one-scan glitch of 'D' during RELEASE → back to PRESSED, no new key_valid, key_down stays 1.
- Reset mid-operation: rst=0 during DEBOUNCE of '9' at cnt=2 → outputs return to reset values at once. Key still held after release → valid only after 3 fresh scans.
